// File: rtl/mp_lut_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : mp_lut_loader_if
//  Brief    : Coefficient stream input and LUT-bank write port of mp_lut_loader.
//  Revision : 1.0
// ============================================================================
interface mp_lut_loader_if #(
    parameter int COEFF_WIDTH = 12,
    parameter int LUT_WIDTH   = 3
);
    logic [31:0]            s_data_i;
    logic                   s_valid_i;
    logic                   s_ready_o;
    logic [31:0]            coeff_data_o;
    logic [COEFF_WIDTH-1:0] coeff_addr_o;
    logic [LUT_WIDTH-1:0]   coeff_num_o;
    logic                   coeff_en_o;

    modport slave (
        input  s_data_i, s_valid_i,
        output s_ready_o, coeff_data_o, coeff_addr_o, coeff_num_o, coeff_en_o
    );

    modport master (
        output s_data_i, s_valid_i,
        input  s_ready_o, coeff_data_o, coeff_addr_o, coeff_num_o, coeff_en_o
    );
endinterface
`default_nettype wire

// File: rtl/mp_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mp_lut_loader
//  Brief    : Sequences stream or constant-fill writes across a range of LUTs.
//  Revision : 1.0
// ============================================================================
module mp_lut_loader #(
    parameter int M           = 3,
    parameter int RESOLUTION  = 4096,
    parameter int COEFF_WIDTH = $clog2(RESOLUTION),
    localparam int LUT_WIDTH  = $clog2(M) + 1
) (
    input  wire logic                 AXI_clk_i,
    input  wire logic                 resetn_i,
    input  wire logic                 start_i,
    input  wire logic                 mode_i,
    input  wire logic [31:0]          fill_data_i,
    input  wire logic [LUT_WIDTH-1:0] lut_first_i,
    input  wire logic [LUT_WIDTH-1:0] lut_last_i,
    input  wire logic                 abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    mp_lut_loader_if.slave            bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [31:0]            fill_q;
    logic [LUT_WIDTH-1:0]   last_q;
    logic [COEFF_WIDTH-1:0] addr_q, addr_d;
    logic [LUT_WIDTH-1:0]   lut_q, lut_d;
    logic [31:0]            coeff_data_q;
    logic [COEFF_WIDTH-1:0] coeff_addr_q;
    logic [LUT_WIDTH-1:0]   coeff_num_q;
    logic                   coeff_en_q;
    logic                   done_q;
    logic                   err_q;
    logic                   w_addr_last;
    logic                   w_final;
    logic                   w_bad_range;

    always_comb begin
        w_addr_last = (addr_q == COEFF_WIDTH'(RESOLUTION - 1));
        w_final     = w_addr_last && (lut_q == last_q);
        addr_d      = w_addr_last ? '0 : addr_q + 1'b1;
        lut_d       = w_addr_last ? lut_q + 1'b1 : lut_q;
        w_bad_range = (lut_first_i > lut_last_i) || (lut_last_i > LUT_WIDTH'(M));
    end

    always_ff @(posedge AXI_clk_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            last_q       <= '0;
            addr_q       <= '0;
            lut_q        <= '0;
            coeff_data_q <= '0;
            coeff_addr_q <= '0;
            coeff_num_q  <= '0;
            coeff_en_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            coeff_en_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        fill_q <= fill_data_i;
                        last_q <= lut_last_i;
                        lut_q  <= lut_first_i;
                        addr_q <= '0;
                        err_q  <= 1'b0;
                        if (w_bad_range) begin
                            err_q <= 1'b1;
                        end else if (mode_i) begin
                            // Fill issues its first write on the start edge so the
                            // strobe is already high in the first busy cycle.
                            coeff_data_q <= fill_data_i;
                            coeff_addr_q <= '0;
                            coeff_num_q  <= lut_first_i;
                            coeff_en_q   <= 1'b1;
                            addr_q       <= COEFF_WIDTH'(1);
                            state_q      <= ST_FILL;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.s_valid_i) begin
                        coeff_data_q <= bus.s_data_i;
                        coeff_addr_q <= addr_q;
                        coeff_num_q  <= lut_q;
                        coeff_en_q   <= 1'b1;
                        addr_q       <= addr_d;
                        lut_q        <= lut_d;
                    end
                    // An accepted word is always written, even under abort.
                    if (abort_i) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (bus.s_valid_i && w_final) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_FILL: begin
                    if (abort_i) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        coeff_data_q <= fill_q;
                        coeff_addr_q <= addr_q;
                        coeff_num_q  <= lut_q;
                        coeff_en_q   <= 1'b1;
                        addr_q       <= addr_d;
                        lut_q        <= lut_d;
                        if (w_final) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o    = (state_q == ST_LOAD);
    assign busy_o           = (state_q == ST_LOAD) || (state_q == ST_FILL);
    assign bus.coeff_data_o = coeff_data_q;
    assign bus.coeff_addr_o = coeff_addr_q;
    assign bus.coeff_num_o  = coeff_num_q;
    assign bus.coeff_en_o   = coeff_en_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mp_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mp_lut_loader
//  Brief    : Randomized scoreboard bench for mp_lut_loader (M=3, RESOLUTION=16).
//  Revision : 1.0
// ============================================================================
module tb_mp_lut_loader;

    localparam int M   = 3;
    localparam int RES = 16;
    localparam int CW  = 4;
    localparam int LW  = 3;

    typedef struct packed {
        logic [31:0]   d;
        logic [CW-1:0] a;
        logic [LW-1:0] n;
        logic          dn;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [31:0]   fill_data = '0;
    logic [LW-1:0] first = '0;
    logic [LW-1:0] last = '0;
    logic          abort = 1'b0;
    logic          busy, done, err;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    bit   stream_chk = 1'b0;
    bit   hs_prev = 1'b0;

    mp_lut_loader_if #(.COEFF_WIDTH(CW), .LUT_WIDTH(LW)) bus ();

    mp_lut_loader #(.M(M), .RESOLUTION(RES), .COEFF_WIDTH(CW)) dut (
        .AXI_clk_i   (clk),
        .resetn_i    (resetn),
        .start_i     (start),
        .mode_i      (mode),
        .fill_data_i (fill_data),
        .lut_first_i (first),
        .lut_last_i  (last),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write is popped against the scoreboard; in stream ops a
    // write must appear exactly in the cycle after a handshake.
    always @(negedge clk) begin
        exp_t e;
        if (bus.coeff_en_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {bus.coeff_num_o, bus.coeff_addr_o}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("write", {bus.coeff_data_o, bus.coeff_addr_o, bus.coeff_num_o, done},
                    {e.d, e.a, e.n, e.dn});
            end
        end else if (done) begin
            chk("done_without_write", 64'(done), 64'd0);
        end
        if (stream_chk) chk("write_follows_handshake", 64'(bus.coeff_en_o), 64'(hs_prev));
        hs_prev = bus.s_valid_i && bus.s_ready_o;
    end

    task automatic do_start(input logic m, input logic [31:0] f,
                            input logic [LW-1:0] fi, input logic [LW-1:0] la);
        start = 1'b1; mode = m; fill_data = f; first = fi; last = la;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle_and_check(input logic err_req);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_op", 64'(busy), 64'd0);
        chk("err_after_op", 64'(err), 64'(err_req));
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // vmode: 0 continuous valid, 1 toggling, 2 random.
    task automatic stream_op(input logic [LW-1:0] fi, input logic [LW-1:0] la, input int vmode,
                             input bit rnd, input int abort_after, input bit poke_start);
        logic [31:0] words[$];
        int n, nwr, sent, cyc;
        bit hs;
        exp_t e;
        n   = (int'(la) - int'(fi) + 1) * RES;
        nwr = (abort_after >= 0) ? abort_after : n;
        for (int k = 0; k < n; k++) words.push_back(rnd ? $urandom : 32'h0001_0000 + k);
        for (int k = 0; k < nwr; k++) begin
            e.d  = words[k];
            e.a  = CW'(k % RES);
            e.n  = LW'(int'(fi) + k / RES);
            e.dn = (abort_after < 0) && (k == n - 1);
            exp_q.push_back(e);
        end
        stream_chk = 1'b1;
        do_start(1'b0, $urandom, fi, la);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(bus.s_ready_o), 64'd1);
        sent = 0;
        cyc  = 0;
        while (sent < nwr && cyc < 4 * n + 20) begin
            bus.s_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
            bus.s_data_i  = words[sent];
            if (poke_start && cyc == 10) begin
                start = 1'b1; mode = 1'b1; first = '0; last = 3'd3;
            end
            @(negedge clk);
            hs = bus.s_valid_i && bus.s_ready_o;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) sent++;
            cyc++;
        end
        bus.s_valid_i = 1'b0;
        chk("stream_words_accepted", 64'(sent), 64'(nwr));
        if (abort_after >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("ready_after_abort", 64'(bus.s_ready_o), 64'd0);
            settle_and_check(1'b1);
        end else begin
            chk("done_on_final_write", 64'({done, busy, bus.s_ready_o}), 64'b100);
            settle_and_check(1'b0);
        end
        stream_chk = 1'b0;
    endtask

    task automatic fill_op(input logic [LW-1:0] fi, input logic [LW-1:0] la,
                           input logic [31:0] f, input int reset_at);
        int n, nwr;
        exp_t e;
        n   = (int'(la) - int'(fi) + 1) * RES;
        nwr = (reset_at >= 0) ? reset_at + 1 : n;
        for (int k = 0; k < nwr; k++) begin
            e.d  = f;
            e.a  = CW'(k % RES);
            e.n  = LW'(int'(fi) + k / RES);
            e.dn = (reset_at < 0) && (k == n - 1);
            exp_q.push_back(e);
        end
        do_start(1'b1, f, fi, la);
        chk("fill_en_first_cycle", 64'({bus.coeff_en_o, busy, bus.s_ready_o}), 64'b110);
        if (reset_at >= 0) begin
            repeat (reset_at) @(posedge clk);
            #1;
            resetn = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
            chk("outputs_zero_after_reset",
                {bus.coeff_data_o, 4'(bus.coeff_addr_o), 4'(bus.coeff_num_o), bus.coeff_en_o,
                 busy, done, err, bus.s_ready_o}, 64'd0);
            settle_and_check(1'b0);
        end else begin
            for (int c = 0; c < n + 10 && exp_q.size() != 0; c++) begin
                @(posedge clk); #1;
            end
            settle_and_check(1'b0);
        end
    endtask

    task automatic bad_range(input logic [LW-1:0] fi, input logic [LW-1:0] la);
        do_start(1'($urandom), $urandom, fi, la);
        chk("bad_range_err", 64'({err, busy, bus.s_ready_o}), 64'b100);
        settle_and_check(1'b1);
    endtask

    initial begin
        logic [LW-1:0] rf, rl;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.coeff_data_o, 4'(bus.coeff_addr_o), 4'(bus.coeff_num_o), bus.coeff_en_o,
             busy, done, err, bus.s_ready_o}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        stream_op(3'd1, 3'd2, 0, 1'b0, -1, 1'b0);
        stream_op(3'd1, 3'd2, 1, 1'b0, -1, 1'b0);
        fill_op(3'd0, 3'd3, 32'h4000_0000, -1);
        bad_range(3'd2, 3'd1);
        bad_range(3'd0, 3'd4);
        stream_op(3'd0, 3'd1, 0, 1'b1, 5, 1'b0);
        stream_op(3'd3, 3'd3, 2, 1'b1, -1, 1'b0);
        fill_op(3'd1, 3'd3, $urandom, 7);
        stream_op(3'd1, 3'd2, 0, 1'b1, -1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rf = LW'($urandom_range(0, 3));
            rl = LW'($urandom_range(int'(rf), 3));
            if ($urandom % 2) fill_op(rf, rl, $urandom, -1);
            else              stream_op(rf, rl, 2, 1'b1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
